home_alarm_ctrl: RTL and testbench
==================================

HOME_ALARM_CTRL -- requirements
Module: home_alarm_ctrl

Interface
REQ-001 Parameter NUM_ZONES, default 4: number of sensor zones (1..16).
REQ-002 Parameter CODE_W, default 5: keypad code width.
REQ-003 Parameter ARM_CODE, default 31: arming code; must differ from DISARM_CODE.
REQ-004 Parameter DISARM_CODE, default 4: disarming code.
REQ-005 Parameter EXIT_DLY, default 8: exit-delay length in cycles (>=1).
REQ-006 Parameter ENTRY_DLY, default 6: entry-delay length in cycles (>=1).
REQ-007 Parameter SIREN_TIME, default 10: alarm duration in cycles before auto re-arm (>=1).
REQ-008 Parameter MAX_TRIES, default 3: wrong codes before lockout.
REQ-009 Parameter LOCK_CYCLES, default 16: lockout duration in cycles.
REQ-010 clk  input  1  system clock, all state updates on rising edge.
REQ-011 rst  input  1  synchronous, active-high reset.
REQ-012 zone  input  NUM_ZONES  level sensor inputs (motion/reed), 1 = tripped.
REQ-013 delayed_mask  input  NUM_ZONES  1 = zone uses entry delay, 0 = instant zone.
REQ-014 code  input  CODE_W  keypad code, sampled only when code_valid=1.
REQ-015 code_valid  input  1  single-cycle code strobe.
REQ-016 active  output  1  1 in EXIT_DELAY, ARMED, ENTRY_DELAY, ALARM.
REQ-017 alarm  output  1  siren drive, 1 only in ALARM.
REQ-018 tripped  output  NUM_ZONES  sticky record of zones that caused a trigger.
REQ-019 lockout  output  1  keypad locked out.

Function
REQ-020 FSM states SHALL be DISARMED, EXIT_DELAY, ARMED, ENTRY_DELAY, ALARM; active/alarm SHALL be Moore decodes of the state register.
REQ-021 DISARMED: valid ARM_CODE -> EXIT_DELAY, timer loaded EXIT_DLY, tripped cleared; all other codes and zones ignored.
REQ-022 EXIT_DELAY: zones ignored; lasts exactly EXIT_DLY cycles then -> ARMED; valid DISARM_CODE -> DISARMED.
REQ-023 ARMED: any tripped instant zone -> ALARM; else any tripped delayed zone -> ENTRY_DELAY, timer loaded ENTRY_DLY.
REQ-024 ENTRY_DELAY: DISARM_CODE -> DISARMED; instant zone -> ALARM immediately; after exactly ENTRY_DLY cycles -> ALARM.
REQ-025 ALARM: timer loaded SIREN_TIME on entry; expiry -> ARMED with alarm=0; DISARM_CODE -> DISARMED.
REQ-026 Zone tripped in ARMED, ENTRY_DELAY or ALARM SHALL set its tripped bit; bits hold until next ARM_CODE acceptance or reset.
REQ-027 Zone asserted at edge k SHALL make alarm=1 after edge k (one-cycle latency) for instant zones in ARMED.
REQ-028 DISARM_CODE and zone trip in same cycle: disarm wins.
REQ-029 ARM_CODE while active SHALL be ignored; codes without code_valid SHALL be ignored.
REQ-030 Zone re-asserting in ALARM SHALL NOT restart the siren timer; re-arm from ALARM with zone still high SHALL re-trigger per REQ-023 on the next cycle.

Reset
REQ-031 rst=1 SHALL force DISARMED, timers 0, tripped=0, active=0, alarm=0, lockout=0, wrong-code count 0, overriding any same-cycle input including mid-alarm.

Configuration
REQ-032 Macro ALARM_LOCKOUT_EN defined: while active, a valid code equal to neither ARM_CODE nor DISARM_CODE increments a wrong-code counter; DISARM_CODE clears it; reaching MAX_TRIES sets lockout=1 for exactly LOCK_CYCLES cycles, counter cleared, all codes ignored; entry/siren timers keep running.
REQ-033 Macro not defined: no counter or lockout timer built, lockout tied 0, wrong codes ignored.

Verification
REQ-034 Reset, ARM_CODE=31 strobe, zone=4'b0001 during exit delay, delayed_mask=0 -> active=1 next cycle, alarm stays 0, ARMED after 8 cycles.
REQ-035 ARMED, zone[2]=1 with delayed_mask[2]=1, no code -> ENTRY_DELAY, alarm=1 after exactly 6 cycles, tripped=4'b0100.
REQ-036 ARMED, zone[0] pulse (instant) -> alarm=1 next cycle for 10 cycles, then alarm=0, active=1 (ARMED), tripped=4'b0001.
REQ-037 ENTRY_DELAY, DISARM_CODE=4 and zone[1] instant same cycle -> DISARMED, active=0, alarm=0.
REQ-038 ALARM_LOCKOUT_EN: codes 7,9,12 while ARMED -> lockout=1 for 16 cycles; DISARM_CODE during lockout ignored; DISARM_CODE after lockout -> DISARMED.
REQ-039 rst asserted mid-ALARM -> all outputs 0 next cycle.

Source files
------------

// File: rtl/home_alarm_ctrl_if.sv
// home_alarm_ctrl_if: sensor/keypad/status bundle for home_alarm_ctrl.
//   zone         sensor levels, 1 = tripped
//   delayed_mask 1 = zone uses entry delay, 0 = instant zone
//   code         keypad code, qualified by code_valid
//   code_valid   single-cycle code strobe
//   active       system armed in any form (exit/armed/entry/alarm)
//   alarm        siren drive
//   tripped      sticky record of zones seen while armed
//   lockout      keypad locked out after too many wrong codes
// master = stimulus/keypad side, slave = controller.
interface home_alarm_ctrl_if #(
  parameter int NUM_ZONES = 4,
  parameter int CODE_W    = 5
);
  logic [NUM_ZONES-1:0] zone;
  logic [NUM_ZONES-1:0] delayed_mask;
  logic [CODE_W-1:0]    code;
  logic                 code_valid;
  logic                 active;
  logic                 alarm;
  logic [NUM_ZONES-1:0] tripped;
  logic                 lockout;

  modport master (
    output zone, delayed_mask, code, code_valid,
    input  active, alarm, tripped, lockout
  );

  modport slave (
    input  zone, delayed_mask, code, code_valid,
    output active, alarm, tripped, lockout
  );
endinterface

// File: rtl/home_alarm_ctrl.sv
// home_alarm_ctrl: home alarm state machine
//   DISARMED -> EXIT_DELAY -> ARMED -> ENTRY_DELAY -> ALARM -> ARMED (auto re-arm).
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  home_alarm_ctrl_if.slave (zone, delayed_mask, code, code_valid in;
//        active, alarm, tripped, lockout out)
// Optional feature: define ALARM_LOCKOUT_EN to build the wrong-code counter
// and keypad lockout timer; otherwise lockout is tied low and wrong codes
// are simply ignored.
module home_alarm_ctrl #(
  parameter int NUM_ZONES   = 4,
  parameter int CODE_W      = 5,
  parameter int ARM_CODE    = 31,
  parameter int DISARM_CODE = 4,
  parameter int EXIT_DLY    = 8,
  parameter int ENTRY_DLY   = 6,
  parameter int SIREN_TIME  = 10,
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 16
) (
  input logic              clk,
  input logic              rst,
  home_alarm_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    DISARMED, EXIT_DELAY, ARMED, ENTRY_DELAY, ALARM
  } state_t;

  // One shared countdown serves exit, entry and siren periods.
  localparam int T_A   = (EXIT_DLY > ENTRY_DLY) ? EXIT_DLY : ENTRY_DLY;
  localparam int T_MAX = (T_A > SIREN_TIME) ? T_A : SIREN_TIME;
  localparam int TW    = $clog2(T_MAX + 1);

  state_t               state;
  logic [TW-1:0]        timer;
  logic [NUM_ZONES-1:0] tripped_q;
  logic                 codes_ok;
  logic                 arm_hit, dis_hit, inst_hit, dly_hit, tmr_done;

  assign arm_hit  = bus.code_valid && codes_ok && (bus.code == CODE_W'(ARM_CODE));
  assign dis_hit  = bus.code_valid && codes_ok && (bus.code == CODE_W'(DISARM_CODE));
  assign inst_hit = |(bus.zone & ~bus.delayed_mask);
  assign dly_hit  = |(bus.zone & bus.delayed_mask);
  // Timer is loaded with N on entry; the state lasts N cycles, leaving when it reads 1.
  assign tmr_done = (timer == TW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DISARMED;
      timer     <= '0;
      tripped_q <= '0;
    end else begin
      if (state inside {ARMED, ENTRY_DELAY, ALARM})
        tripped_q <= tripped_q | bus.zone;
      case (state)
        DISARMED: if (arm_hit) begin
          state     <= EXIT_DELAY;
          timer     <= TW'(EXIT_DLY);
          tripped_q <= '0;
        end
        EXIT_DELAY: begin
          if (dis_hit) begin
            state <= DISARMED;
            timer <= '0;
          end else if (tmr_done) begin
            state <= ARMED;
            timer <= '0;
          end else
            timer <= timer - TW'(1);
        end
        ARMED: begin
          // Disarm beats any simultaneous zone trip.
          if (dis_hit)
            state <= DISARMED;
          else if (inst_hit) begin
            state <= ALARM;
            timer <= TW'(SIREN_TIME);
          end else if (dly_hit) begin
            state <= ENTRY_DELAY;
            timer <= TW'(ENTRY_DLY);
          end
        end
        ENTRY_DELAY: begin
          if (dis_hit) begin
            state <= DISARMED;
            timer <= '0;
          end else if (inst_hit || tmr_done) begin
            state <= ALARM;
            timer <= TW'(SIREN_TIME);
          end else
            timer <= timer - TW'(1);
        end
        ALARM: begin
          // Zones are not consulted here, so a held zone cannot extend the siren;
          // it re-triggers from ARMED on the cycle after re-arm.
          if (dis_hit) begin
            state <= DISARMED;
            timer <= '0;
          end else if (tmr_done) begin
            state <= ARMED;
            timer <= '0;
          end else
            timer <= timer - TW'(1);
        end
        default: begin
          state <= DISARMED;
          timer <= '0;
        end
      endcase
    end
  end

  assign bus.active  = (state != DISARMED);
  assign bus.alarm   = (state == ALARM);
  assign bus.tripped = tripped_q;

`ifdef ALARM_LOCKOUT_EN
  localparam int CW = $clog2(MAX_TRIES + 1);
  localparam int LW = $clog2(LOCK_CYCLES + 1);

  logic [CW-1:0] wrong_cnt;
  logic [LW-1:0] lock_tmr;
  logic          lock_q;
  logic          wrong_hit;

  assign codes_ok  = !lock_q;
  assign wrong_hit = bus.code_valid && codes_ok && (state != DISARMED) &&
                     (bus.code != CODE_W'(ARM_CODE)) && (bus.code != CODE_W'(DISARM_CODE));

  always_ff @(posedge clk) begin
    if (rst) begin
      wrong_cnt <= '0;
      lock_tmr  <= '0;
      lock_q    <= 1'b0;
    end else if (lock_q) begin
      if (lock_tmr == LW'(1)) lock_q <= 1'b0;
      lock_tmr <= lock_tmr - LW'(1);
    end else if (wrong_hit) begin
      if (wrong_cnt == CW'(MAX_TRIES - 1)) begin
        wrong_cnt <= '0;
        lock_q    <= 1'b1;
        lock_tmr  <= LW'(LOCK_CYCLES);
      end else
        wrong_cnt <= wrong_cnt + CW'(1);
    end else if (dis_hit)
      wrong_cnt <= '0;
  end

  assign bus.lockout = lock_q;
`else
  assign codes_ok    = 1'b1;
  assign bus.lockout = 1'b0;
`endif

endmodule

// File: tb/tb_home_alarm_ctrl.sv
// tb_home_alarm_ctrl: directed + random stimulus against a deadline-based
// behavioural model; every cycle's outputs are compared on the falling edge.
module tb_home_alarm_ctrl;
  localparam int NZ = 4, CW = 5, ARM = 31, DIS = 4;
  localparam int EXIT = 8, ENTRY = 6, SIREN = 10, MAXT = 3, LOCK = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  home_alarm_ctrl_if #(.NUM_ZONES(NZ), .CODE_W(CW)) bus ();

  home_alarm_ctrl #(
    .NUM_ZONES(NZ), .CODE_W(CW), .ARM_CODE(ARM), .DISARM_CODE(DIS),
    .EXIT_DLY(EXIT), .ENTRY_DLY(ENTRY), .SIREN_TIME(SIREN),
    .MAX_TRIES(MAXT), .LOCK_CYCLES(LOCK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors = 0, miscompares = 0;

  // Model: mode plus absolute edge numbers at which timed periods end.
  localparam int M_OFF = 0, M_EXIT = 1, M_ARMED = 2, M_ENTRY = 3, M_ALARM = 4;
  int m_mode = M_OFF;
  int now = 0;          // index of the most recent clock edge
  int deadline = 0;     // edge at which the current timed period ends
  int lock_end = 0;     // lockout shows while now < lock_end
  int wrong = 0;
  logic [NZ-1:0] m_trp = '0;

  task automatic m_step(input logic r, input logic [NZ-1:0] z, input logic [NZ-1:0] dm,
                        input logic [CW-1:0] c, input logic cv);
    bit ok, dis, arm, inst, del, act;
    ok = !(now < lock_end);
    now++;
    if (r) begin
      m_mode = M_OFF; m_trp = '0; wrong = 0; lock_end = now; deadline = now;
      return;
    end
    act  = (m_mode != M_OFF);
    dis  = cv && ok && (c == CW'(DIS));
    arm  = cv && ok && (c == CW'(ARM));
    inst = |(z & ~dm);
    del  = |(z & dm);
    if (m_mode == M_ARMED || m_mode == M_ENTRY || m_mode == M_ALARM) m_trp |= z;
`ifdef ALARM_LOCKOUT_EN
    if (act && cv && ok && c != CW'(ARM) && c != CW'(DIS)) begin
      wrong++;
      if (wrong == MAXT) begin wrong = 0; lock_end = now + LOCK; end
    end else if (dis) wrong = 0;
`endif
    case (m_mode)
      M_OFF:   if (arm) begin m_mode = M_EXIT; deadline = now + EXIT; m_trp = '0; end
      M_EXIT:  if (dis) m_mode = M_OFF; else if (now == deadline) m_mode = M_ARMED;
      M_ARMED: if (dis) m_mode = M_OFF;
               else if (inst) begin m_mode = M_ALARM; deadline = now + SIREN; end
               else if (del) begin m_mode = M_ENTRY; deadline = now + ENTRY; end
      M_ENTRY: if (dis) m_mode = M_OFF;
               else if (inst || now == deadline) begin m_mode = M_ALARM; deadline = now + SIREN; end
      default: if (dis) m_mode = M_OFF; else if (now == deadline) m_mode = M_ARMED;
    endcase
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", nm, now, got, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, compare after the edge.
  task automatic tick(input logic r, input logic [NZ-1:0] z, input logic [NZ-1:0] dm,
                      input logic [CW-1:0] c, input logic cv);
    rst = r; bus.zone = z; bus.delayed_mask = dm; bus.code = c; bus.code_valid = cv;
    m_step(r, z, dm, c, cv);
    @(negedge clk);
    chk("active",  32'(bus.active),  32'(m_mode != M_OFF));
    chk("alarm",   32'(bus.alarm),   32'(m_mode == M_ALARM));
    chk("tripped", 32'(bus.tripped), 32'(m_trp));
    chk("lockout", 32'(bus.lockout), 32'(now < lock_end));
  endtask

  task automatic idle(input int n, input logic [NZ-1:0] dm);
    for (int i = 0; i < n; i++) tick(0, '0, dm, '0, 0);
  endtask

  task automatic arm_up();  // from DISARMED to ARMED
    tick(0, '0, '0, CW'(ARM), 1);
    idle(EXIT, '0);
  endtask

  logic [NZ-1:0] rz, rdm;
  logic [CW-1:0] rc;
  logic rcv, rr;
  int sel;

  initial begin
    tick(1, '0, '0, '0, 0);
    tick(1, '0, '0, CW'(ARM), 1);
    chk("rst_active", 32'(bus.active), 0);
    chk("rst_tripped", 32'(bus.tripped), 0);

    // Arm with an instant zone high during the whole exit delay.
    tick(0, 4'b0001, '0, CW'(ARM), 1);
    chk("arm_active", 32'(bus.active), 1);
    for (int i = 0; i < EXIT - 1; i++) tick(0, 4'b0001, '0, '0, 0);
    chk("exit_alarm", 32'(bus.alarm), 0);
    tick(0, '0, '0, '0, 0);
    chk("armed_active", 32'(bus.active), 1);

    // Instant pulse: siren for SIREN cycles then auto re-arm.
    tick(0, 4'b0001, '0, '0, 0);
    chk("inst_alarm", 32'(bus.alarm), 1);
    idle(SIREN - 1, '0);
    chk("siren_last", 32'(bus.alarm), 1);
    idle(1, '0);
    chk("rearm_alarm", 32'(bus.alarm), 0);
    chk("rearm_active", 32'(bus.active), 1);
    chk("inst_tripped", 32'(bus.tripped), 32'h1);

    // Delayed zone: entry delay then alarm.
    tick(0, '0, '0, CW'(DIS), 1);
    chk("disarm", 32'(bus.active), 0);
    arm_up();
    tick(0, 4'b0100, 4'b0100, '0, 0);
    idle(ENTRY - 1, 4'b0100);
    chk("entry_wait", 32'(bus.alarm), 0);
    idle(1, 4'b0100);
    chk("entry_alarm", 32'(bus.alarm), 1);
    chk("entry_tripped", 32'(bus.tripped), 32'h4);

    // Disarm beats an instant zone in entry delay.
    tick(0, '0, '0, CW'(DIS), 1);
    arm_up();
    tick(0, 4'b0100, 4'b0100, '0, 0);
    tick(0, 4'b0010, 4'b0100, CW'(DIS), 1);
    chk("dis_win_active", 32'(bus.active), 0);
    chk("dis_win_alarm", 32'(bus.alarm), 0);

    // Held zone: siren not extended, re-triggers right after re-arm.
    arm_up();
    tick(0, 4'b0001, '0, '0, 0);
    for (int i = 0; i < SIREN - 1; i++) tick(0, 4'b0001, '0, '0, 0);
    chk("held_alarm", 32'(bus.alarm), 1);
    tick(0, 4'b0001, '0, '0, 0);
    chk("held_rearm", 32'(bus.alarm), 0);
    tick(0, 4'b0001, '0, '0, 0);
    chk("held_retrig", 32'(bus.alarm), 1);

    // Reset mid-alarm overrides everything.
    tick(1, 4'b0001, '0, CW'(ARM), 1);
    chk("rst_mid_active", 32'(bus.active), 0);
    chk("rst_mid_alarm", 32'(bus.alarm), 0);
    chk("rst_mid_tripped", 32'(bus.tripped), 0);

    // Wrong codes while armed.
    arm_up();
    tick(0, '0, '0, CW'(7), 1);
    tick(0, '0, '0, CW'(9), 1);
    tick(0, '0, '0, CW'(12), 1);
`ifdef ALARM_LOCKOUT_EN
    chk("lock_set", 32'(bus.lockout), 1);
    tick(0, '0, '0, CW'(DIS), 1);
    chk("lock_dis_ign", 32'(bus.active), 1);
    idle(LOCK - 2, '0);
    chk("lock_last", 32'(bus.lockout), 1);
    idle(1, '0);
    chk("lock_clr", 32'(bus.lockout), 0);
`else
    chk("no_lock", 32'(bus.lockout), 0);
`endif
    tick(0, '0, '0, CW'(DIS), 1);
    chk("dis_after", 32'(bus.active), 0);

    // Random phase.
    rdm = '0;
    for (int n = 0; n < 3000; n++) begin
      rr  = ($urandom_range(0, 399) == 0);
      rz  = ($urandom_range(0, 9) == 0) ? NZ'($urandom) : '0;
      if ($urandom_range(0, 49) == 0) rdm = NZ'($urandom);
      rcv = ($urandom_range(0, 7) == 0);
      sel = $urandom_range(0, 9);
      rc  = (sel < 4) ? CW'(ARM) : (sel < 6) ? CW'(DIS) : CW'($urandom);
      tick(rr, rz, rdm, rc, rcv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
